// File: rtl/instr_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and
// instruction memory (slave).
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned byte address of the fetch
//   imem_rdata : instruction word, valid while imem_ack=1
//   imem_ack   : one-cycle fetch completion strobe
interface instr_fetch_sequencer_if #(
  parameter int unsigned PC_W = 32
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// CPU front end: owns the PC, fetches 32-bit instructions over the imem
// req/ack handshake, splits the instruction register into decoder fields and
// resolves j/beq/bne against the ALU zero flag to form the next PC.
// Ports:
//   CLK, RESET_N : clock (rising edge) and asynchronous active-low reset
//   run          : permission to start a new fetch (sampled in IDLE/RESOLVE)
//   imem         : fetch bus (master side)
//   opcode, rd_off, rt, rs_imm : fields of the instruction register
//   instr_valid  : one-cycle strobe, fields hold a newly fetched instruction
//   alu_zero     : ALU zero flag, sampled in RESOLVE
//   pc           : current instruction address
//   illegal_op   : sticky flag, an opcode above 8'h09 was fetched
module instr_fetch_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         run,
  instr_fetch_sequencer_if.master      imem,
  output logic [7:0]                   opcode,
  output logic [7:0]                   rd_off,
  output logic [7:0]                   rt,
  output logic [7:0]                   rs_imm,
  output logic                         instr_valid,
  input  logic                         alu_zero,
  output logic [PC_W-1:0]              pc,
  output logic                         illegal_op
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ISSUE   = 2'd2,
    S_RESOLVE = 2'd3
  } state_t;

  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_LAST  = 8'h09;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;
  logic            taken_s;
  logic [PC_W-1:0] seq_pc_s;
  logic [PC_W-1:0] target_pc_s;

  // Branch target: pc + 4 + (sign-extended word offset << 2), wrapping.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0] cur_pc,
    input logic [7:0]      off
  );
    logic [PC_W-1:0] off_ext;
    off_ext = {{(PC_W-8){off[7]}}, off};
    return cur_pc + {{(PC_W-3){1'b0}}, 3'd4} + (off_ext << 2);
  endfunction

  // Branch decision from the current opcode and the ALU zero flag.
  always_comb begin
    taken_s = 1'b0;
    case (ir_q[31:24])
      OP_J:    taken_s = 1'b1;
      OP_BEQ:  taken_s = alu_zero;
      OP_BNE:  taken_s = ~alu_zero;
      default: taken_s = 1'b0;
    endcase
  end

  assign seq_pc_s    = pc_q + {{(PC_W-3){1'b0}}, 3'd4};
  assign target_pc_s = branch_target(pc_q, ir_q[23:16]);

  // Next-state, next-PC and instruction-register logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = S_ISSUE;
          // Flag is raised together with the ISSUE strobe it belongs to.
          if (imem.imem_rdata[31:24] > OP_LAST) begin
            illegal_d = 1'b1;
          end else begin
            illegal_d = illegal_q;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (taken_s) begin
          pc_d = target_pc_s;
        end else begin
          pc_d = seq_pc_s;
        end
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Request and strobe are registered decodes of the next state.
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_ISSUE);
  end

  // State, PC, instruction register and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign opcode         = ir_q[31:24];
  assign rd_off         = ir_q[23:16];
  assign rt             = ir_q[15:8];
  assign rs_imm         = ir_q[7:0];
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign illegal_op     = illegal_q;

endmodule
